// File: rtl/ex_divider_pkg.sv
// Shared types and constants for the EX-stage divider.
// Holds op-type bit positions, iteration limits and FSM states.
package ex_divider_pkg;

  localparam int DATA_W     = 64;
  localparam int DIV_TYPE_W = 3;
  localparam int DIV_ITER_W = 6;

  localparam int TYPE_UNS  = 0;
  localparam int TYPE_REM  = 1;
  localparam int TYPE_WORD = 2;

  localparam logic [DATA_W-1:0] ZERO_DWORD = '0;

  localparam logic [DIV_ITER_W-1:0] ITER_LAST_D = 6'd63;
  localparam logic [DIV_ITER_W-1:0] ITER_LAST_W = 6'd31;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIXUP,
    DIV_DONE
  } div_state_e;

  function automatic logic [DATA_W-1:0] sext32(
    input logic [31:0] v
  );
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ex_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU and word forms.
// Ports: clk, rst_n, div_valid/div_type/rs1_data/rs2_data, flush, res_ready; div_ready, res_valid, div_res.
module ex_divider
  import ex_divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  div_valid,
  input  logic [DIV_TYPE_W-1:0] div_type,
  input  logic [DATA_W-1:0]     rs1_data,
  input  logic [DATA_W-1:0]     rs2_data,
  input  logic                  flush,
  input  logic                  res_ready,
  output logic                  div_ready,
  output logic                  res_valid,
  output logic [DATA_W-1:0]     div_res
);

  div_state_e             state_q;
  logic [DIV_ITER_W-1:0]  cnt_q;
  logic [DATA_W-1:0]      rem_q;
  logic [DATA_W-1:0]      quo_q;
  logic [DATA_W-1:0]      dvs_q;
  logic                   rem_op_q;
  logic                   word_q;
  logic                   q_neg_q;
  logic                   r_neg_q;

  logic              is_word;
  logic              is_uns;
  logic [DATA_W-1:0] a_ext;
  logic [DATA_W-1:0] b_ext;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic              by_zero;
  logic              ovf;
  logic [DATA_W-1:0] spec_raw;
  logic [DATA_W-1:0] spec_res;

  always_comb begin
    is_word = div_type[TYPE_WORD];
    is_uns  = div_type[TYPE_UNS];
    if (is_word) begin
      a_ext = is_uns ? {32'b0, rs1_data[31:0]}
                     : sext32(rs1_data[31:0]);
      b_ext = is_uns ? {32'b0, rs2_data[31:0]}
                     : sext32(rs2_data[31:0]);
    end else begin
      a_ext = rs1_data;
      b_ext = rs2_data;
    end
    a_neg   = ~is_uns & a_ext[DATA_W-1];
    b_neg   = ~is_uns & b_ext[DATA_W-1];
    a_mag   = a_neg ? -a_ext : a_ext;
    b_mag   = b_neg ? -b_ext : b_ext;
    by_zero = (b_ext == ZERO_DWORD);
    ovf     = ~is_uns & (b_ext == '1)
            & (is_word ? (a_ext == sext32(32'h8000_0000))
                       : (a_ext == {1'b1, 63'b0}));
    if (by_zero)
      spec_raw = div_type[TYPE_REM] ? a_ext : '1;
    else
      spec_raw = div_type[TYPE_REM] ? ZERO_DWORD : a_ext;
    spec_res = is_word ? sext32(spec_raw[31:0]) : spec_raw;
  end

  // One restoring step: shift the next dividend bit into the
  // partial remainder and keep the difference if it is non-negative.
  logic [DATA_W:0]   part;
  logic              ge;
  logic [DATA_W-1:0] rem_nxt;

  always_comb begin
    part    = {rem_q, quo_q[DATA_W-1]};
    ge      = (part >= {1'b0, dvs_q});
    rem_nxt = ge ? (part[DATA_W-1:0] - dvs_q) : part[DATA_W-1:0];
  end

  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;
  logic [DATA_W-1:0] fix_raw;
  logic [DATA_W-1:0] fix_res;

  always_comb begin
    q_fix   = q_neg_q ? -quo_q : quo_q;
    r_fix   = r_neg_q ? -rem_q : rem_q;
    fix_raw = rem_op_q ? r_fix : q_fix;
    fix_res = word_q ? sext32(fix_raw[31:0]) : fix_raw;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_op_q  <= 1'b0;
      word_q    <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      div_ready <= 1'b1;
      res_valid <= 1'b0;
      div_res   <= ZERO_DWORD;
    end else if (flush) begin
      state_q   <= DIV_IDLE;
      div_ready <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (div_valid) begin
            rem_op_q  <= div_type[TYPE_REM];
            word_q    <= is_word;
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            rem_q     <= '0;
            dvs_q     <= b_mag;
            // Word dividends sit in the top half so the
            // MSB-first walk only needs 32 steps.
            quo_q     <= is_word ? {a_mag[31:0], 32'b0} : a_mag;
            div_ready <= 1'b0;
            if (by_zero || ovf) begin
              div_res   <= spec_res;
              res_valid <= 1'b1;
              state_q   <= DIV_DONE;
            end else begin
              cnt_q   <= is_word ? ITER_LAST_W : ITER_LAST_D;
              state_q <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          rem_q <= rem_nxt;
          quo_q <= {quo_q[DATA_W-2:0], ge};
          if (cnt_q == '0)
            state_q <= DIV_FIXUP;
          else
            cnt_q <= cnt_q - 1'b1;
        end
        DIV_FIXUP: begin
          div_res   <= fix_res;
          res_valid <= 1'b1;
          state_q   <= DIV_DONE;
        end
        DIV_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            div_ready <= 1'b1;
            state_q   <= DIV_IDLE;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

endmodule
